// File: rtl/fifo_pkg.sv
// Shared helpers for the single-clock FIFO: depth/pointer sizing derived from
// DEPTH_LOG2 and the parameter legality check used at elaboration.
package fifo_pkg;

    // Read-mode encoding for the FWFT parameter.
    typedef enum logic {
        RD_STANDARD = 1'b0,
        RD_FWFT     = 1'b1
    } read_mode_e;

    // Number of storage entries for a given address width.
    function automatic int fifo_depth(input int depth_log2);
        return 1 << depth_log2;
    endfunction

    // Pointers carry one extra wrap bit above the address bits.
    function automatic int fifo_ptr_width(input int depth_log2);
        return depth_log2 + 1;
    endfunction

    // True when the threshold and mode parameters describe a usable FIFO.
    function automatic bit fifo_params_legal(input int depth_log2,
                                             input int af_thresh,
                                             input int ae_thresh,
                                             input int fwft);
        int depth;
        depth = fifo_depth(depth_log2);
        return (depth_log2 >= 1)
            && (af_thresh >= 1) && (af_thresh <= depth)
            && (ae_thresh >= 0) && (ae_thresh <= depth - 1)
            && ((fwft == 0) || (fwft == 1));
    endfunction

endpackage

// File: rtl/fifo_sync_ram.sv
// Flop-based storage for the FIFO: synchronous write, combinational read.
// Storage is deliberately not reset; the pointers define what is valid.
module fifo_sync_ram
    import fifo_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    localparam int DEPTH = fifo_depth(ADDR_W);

    logic [WIDTH-1:0] mem [0:DEPTH-1];

    // Write port: one word per cycle at the write address.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port is asynchronous so FWFT mode can show the head word directly.
    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with occupancy count, programmable
// almost-full/almost-empty flags, overflow/underflow pulses and an optional
// first-word-fall-through read mode.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int MEM_WIDTH  = 32,
    parameter int DEPTH_LOG2 = 7,
    parameter int AF_THRESH  = 120,
    parameter int AE_THRESH  = 8,
    parameter int FWFT       = 0
) (
    input  logic                  clk_in,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  insert,
    input  logic [MEM_WIDTH-1:0]  data_in,
    input  logic                  remove,
    output logic [MEM_WIDTH-1:0]  data_out,
    output logic                  data_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int PTR_W = fifo_ptr_width(DEPTH_LOG2);
    localparam logic [PTR_W-1:0] AF_LIMIT = PTR_W'(AF_THRESH);
    localparam logic [PTR_W-1:0] AE_LIMIT = PTR_W'(AE_THRESH);

    // Out-of-range thresholds or mode stop elaboration.
    if (!fifo_params_legal(DEPTH_LOG2, AF_THRESH, AE_THRESH, FWFT)) begin : g_param_check
        $error("sync_fifo_param: illegal DEPTH_LOG2/AF_THRESH/AE_THRESH/FWFT combination");
    end

    logic [PTR_W-1:0]     wptr_reg, wptr_next;
    logic [PTR_W-1:0]     rptr_reg, rptr_next;
    logic                 overflow_reg, underflow_reg;
    logic                 full_flag, empty_flag;
    logic                 wr_accept, rd_accept;
    logic [MEM_WIDTH-1:0] ram_rdata;

    // Status is decoded from the registered pointers only.
    assign full_flag  = (wptr_reg[DEPTH_LOG2-1:0] == rptr_reg[DEPTH_LOG2-1:0])
                     && (wptr_reg[DEPTH_LOG2] != rptr_reg[DEPTH_LOG2]);
    assign empty_flag = (wptr_reg == rptr_reg);
    assign count      = wptr_reg - rptr_reg;

    assign full         = full_flag;
    assign empty        = empty_flag;
    assign almost_full  = (count >= AF_LIMIT);
    assign almost_empty = (count <= AE_LIMIT);
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;

    // Requests are qualified by the flags at the start of the cycle, so a
    // full FIFO still drains and an empty FIFO still fills on insert+remove.
    assign wr_accept = insert && !full_flag;
    assign rd_accept = remove && !empty_flag;

    // Next-pointer selection; flush overrides any access in the same cycle.
    always_comb begin
        wptr_next = wptr_reg;
        rptr_next = rptr_reg;
        if (flush) begin
            wptr_next = '0;
            rptr_next = '0;
        end else begin
            if (wr_accept) begin
                wptr_next = wptr_reg + 1'b1;
            end
            if (rd_accept) begin
                rptr_next = rptr_reg + 1'b1;
            end
        end
    end

    // Pointer registers.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            wptr_reg <= '0;
            rptr_reg <= '0;
        end else begin
            wptr_reg <= wptr_next;
            rptr_reg <= rptr_next;
        end
    end

    // One-cycle error pulses for rejected requests; cleared by flush.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else if (flush) begin
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            overflow_reg  <= insert && full_flag;
            underflow_reg <= remove && empty_flag;
        end
    end

    fifo_sync_ram #(
        .WIDTH  (MEM_WIDTH),
        .ADDR_W (DEPTH_LOG2)
    ) u_ram (
        .clk   (clk_in),
        .we    (wr_accept && !flush),
        .waddr (wptr_reg[DEPTH_LOG2-1:0]),
        .wdata (data_in),
        .raddr (rptr_reg[DEPTH_LOG2-1:0]),
        .rdata (ram_rdata)
    );

    if (FWFT == 0) begin : g_std_read
        logic [MEM_WIDTH-1:0] data_out_reg;
        logic                 data_valid_reg;

        // Registered read: the head word is captured on the accepting edge
        // and data_valid marks exactly the following cycle.
        always_ff @(posedge clk_in or negedge reset) begin
            if (!reset) begin
                data_out_reg   <= '0;
                data_valid_reg <= 1'b0;
            end else if (flush) begin
                data_valid_reg <= 1'b0;
            end else begin
                data_valid_reg <= rd_accept;
                if (rd_accept) begin
                    data_out_reg <= ram_rdata;
                end
            end
        end

        assign data_out   = data_out_reg;
        assign data_valid = data_valid_reg;
    end else begin : g_fwft_read
        // Head word is presented directly; zero while empty so stale storage
        // never leaks out (this also gives data_out=0 during reset).
        assign data_out   = empty_flag ? '0 : ram_rdata;
        assign data_valid = !empty_flag;
    end

endmodule
